// File: rtl/exchange_decider_if.sv
// Operand/result handshake bundle for the FP add/sub exchange decider.
// master = upstream/downstream environment, slave = the decider itself.
interface exchange_decider_if;
  logic        in_valid;
  logic        in_ready;
  logic        op_subtract;
  logic        sign_a;
  logic [7:0]  exponent_a;
  logic [23:0] fraction_a;
  logic        sign_b;
  logic [7:0]  exponent_b;
  logic [23:0] fraction_b;

  logic        out_valid;
  logic        out_ready;
  logic        exchange_operands;
  logic [4:0]  shift_amount;
  logic        effective_subtract;
  logic        out_sign_a;
  logic [7:0]  out_exponent_a;
  logic [23:0] out_fraction_a;
  logic        out_sign_b;
  logic [7:0]  out_exponent_b;
  logic [23:0] out_fraction_b;

  modport master (
    output in_valid, op_subtract, sign_a, exponent_a, fraction_a,
           sign_b, exponent_b, fraction_b, out_ready,
    input  in_ready, out_valid, exchange_operands, shift_amount, effective_subtract,
           out_sign_a, out_exponent_a, out_fraction_a,
           out_sign_b, out_exponent_b, out_fraction_b
  );

  modport slave (
    input  in_valid, op_subtract, sign_a, exponent_a, fraction_a,
           sign_b, exponent_b, fraction_b, out_ready,
    output in_ready, out_valid, exchange_operands, shift_amount, effective_subtract,
           out_sign_a, out_exponent_a, out_fraction_a,
           out_sign_b, out_exponent_b, out_fraction_b
  );
endinterface

// File: rtl/exchange_decider.sv
// Two-stage front of the FP add/sub path: swap decision, saturated align shift, effective op.
// Optional macro SIGN_TIEBREAK_EN: on equal magnitude, swap so the positive operand is sorted A.
module exchange_decider #(
  parameter int unsigned SHIFT_SAT = 31
) (
  input  logic          clk,
  input  logic          reset,
  exchange_decider_if.slave bus
);

  logic        s1_valid, s2_valid;
  logic        s1_advance, s2_advance;

  logic        s1_sign_a, s1_sign_b;
  logic [7:0]  s1_exp_a, s1_exp_b;
  logic [23:0] s1_frac_a, s1_frac_b;
  logic        s1_exp_gt_b, s1_exp_eq, s1_frac_gt_b;
  logic [8:0]  s1_exp_diff;

  logic [8:0]  abs_diff;
  logic [4:0]  shift_next;
  logic        exch_next;

  assign s2_advance  = !s2_valid | bus.out_ready;
  assign s1_advance  = !s1_valid | s2_advance;
  assign bus.in_ready = s1_advance;

  // S1: capture operands with op_subtract folded into sign_b, plus raw compares
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_sign_a    <= 1'b0;
      s1_sign_b    <= 1'b0;
      s1_exp_a     <= '0;
      s1_exp_b     <= '0;
      s1_frac_a    <= '0;
      s1_frac_b    <= '0;
      s1_exp_gt_b  <= 1'b0;
      s1_exp_eq    <= 1'b0;
      s1_frac_gt_b <= 1'b0;
      s1_exp_diff  <= '0;
    end else if (s1_advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_a    <= bus.sign_a;
        s1_sign_b    <= bus.sign_b ^ bus.op_subtract;
        s1_exp_a     <= bus.exponent_a;
        s1_exp_b     <= bus.exponent_b;
        s1_frac_a    <= bus.fraction_a;
        s1_frac_b    <= bus.fraction_b;
        s1_exp_gt_b  <= bus.exponent_b > bus.exponent_a;
        s1_exp_eq    <= bus.exponent_b == bus.exponent_a;
        s1_frac_gt_b <= bus.fraction_b > bus.fraction_a;
        s1_exp_diff  <= {1'b0, bus.exponent_a} - {1'b0, bus.exponent_b};
      end
    end
  end

  // |exp_diff| fits in 8 bits, so the 9-bit two's-complement negate never overflows
  always_comb begin
    abs_diff   = s1_exp_diff[8] ? (~s1_exp_diff + 9'd1) : s1_exp_diff;
    shift_next = (abs_diff > 9'(SHIFT_SAT)) ? 5'(SHIFT_SAT) : abs_diff[4:0];
`ifdef SIGN_TIEBREAK_EN
    exch_next  = s1_exp_gt_b | (s1_exp_eq & s1_frac_gt_b)
               | (s1_exp_eq & (s1_frac_a == s1_frac_b) & s1_sign_a & ~s1_sign_b);
`else
    exch_next  = s1_exp_gt_b | (s1_exp_eq & s1_frac_gt_b);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid               <= 1'b0;
      bus.exchange_operands  <= 1'b0;
      bus.shift_amount       <= '0;
      bus.effective_subtract <= 1'b0;
      bus.out_sign_a         <= 1'b0;
      bus.out_exponent_a     <= '0;
      bus.out_fraction_a     <= '0;
      bus.out_sign_b         <= 1'b0;
      bus.out_exponent_b     <= '0;
      bus.out_fraction_b     <= '0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        bus.exchange_operands  <= exch_next;
        bus.shift_amount       <= shift_next;
        bus.effective_subtract <= s1_sign_a ^ s1_sign_b;
        bus.out_sign_a         <= s1_sign_a;
        bus.out_exponent_a     <= s1_exp_a;
        bus.out_fraction_a     <= s1_frac_a;
        bus.out_sign_b         <= s1_sign_b;
        bus.out_exponent_b     <= s1_exp_b;
        bus.out_fraction_b     <= s1_frac_b;
      end
    end
  end

  assign bus.out_valid = s2_valid;

endmodule

// File: tb/tb_exchange_decider.sv
// Self-checking bench for exchange_decider: directed cases, backpressure, random stream, reset.
module tb_exchange_decider;
  localparam int SAT = 31;
`ifdef SIGN_TIEBREAK_EN
  localparam bit TIE = 1'b1;
`else
  localparam bit TIE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  exchange_decider_if dif();
  exchange_decider #(.SHIFT_SAT(SAT)) dut (.clk(clk), .reset(reset), .bus(dif));

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        op;
    logic        sa;
    logic [7:0]  ea;
    logic [23:0] fa;
    logic        sb;
    logic [7:0]  eb;
    logic [23:0] fb;
  } stim_t;
  typedef logic [72:0] res_t;

  res_t sb_q[$];

  // Expected outputs straight from the arithmetic definition of each field
  function automatic res_t model(stim_t s);
    int d;
    int sh;
    logic exch;
    logic sbe;
    sbe = s.sb ^ s.op;
    d = int'(s.ea) - int'(s.eb);
    if (d < 0) d = -d;
    sh = (d > SAT) ? SAT : d;
    exch = (s.eb > s.ea) || (s.eb == s.ea && s.fb > s.fa);
    if (TIE && s.eb == s.ea && s.fb == s.fa && s.sa && !sbe) exch = 1'b1;
    return {exch, 5'(sh), s.sa ^ sbe, s.sa, s.ea, s.fa, sbe, s.eb, s.fb};
  endfunction

  function automatic res_t observed();
    return {dif.exchange_operands, dif.shift_amount, dif.effective_subtract,
            dif.out_sign_a, dif.out_exponent_a, dif.out_fraction_a,
            dif.out_sign_b, dif.out_exponent_b, dif.out_fraction_b};
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.op = 1'($urandom); s.sa = 1'($urandom); s.sb = 1'($urandom);
    s.ea = 8'($urandom);
    s.fa = {1'b1, 23'($urandom)};
    s.fb = {1'b1, 23'($urandom)};
    case ($urandom_range(0, 4))
      0: s.eb = 8'($urandom);
      1: s.eb = s.ea + 8'($urandom_range(0, 6)) - 8'd3;
      2: s.eb = s.ea;
      3: begin s.eb = s.ea; s.fb = s.fa; end
      default: begin s.eb = 8'($urandom); s.fa = 24'($urandom); end
    endcase
    return s;
  endfunction

  task automatic drive(input stim_t s, input logic v);
    dif.in_valid    = v;
    dif.op_subtract = s.op;
    dif.sign_a      = s.sa;
    dif.exponent_a  = s.ea;
    dif.fraction_a  = s.fa;
    dif.sign_b      = s.sb;
    dif.exponent_b  = s.eb;
    dif.fraction_b  = s.fb;
  endtask

  task automatic test_reset();
    drive('0, 1'b0);
    dif.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dif.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b expected 0", dif.out_valid);
    end
    checks++;
    if (observed() !== '0) begin
      failures++; $display("FAIL reset_data: got %h expected 0", observed());
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dif.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b expected 1", dif.in_ready);
    end
  endtask

  // Single isolated transactions: exact two-clock latency and hand-derived field values
  task automatic test_directed();
    stim_t cs[4];
    logic [7:0] ex[4];  // {exch, shift[4:0], eff_sub, out_sign_b}
    cs[0] = '{op:0, sa:0, ea:8'd127, fa:24'h800000, sb:0, eb:8'd128, fb:24'h800000};
    cs[1] = '{op:1, sa:0, ea:8'd100, fa:24'h800000, sb:0, eb:8'd100, fb:24'hC00000};
    cs[2] = '{op:0, sa:0, ea:8'd254, fa:24'h800000, sb:0, eb:8'd1,   fb:24'h800000};
    cs[3] = '{op:0, sa:1, ea:8'd130, fa:24'h900000, sb:0, eb:8'd130, fb:24'h900000};
    ex[0] = {1'b1, 5'd1,  1'b0, 1'b0};
    ex[1] = {1'b1, 5'd0,  1'b1, 1'b1};
    ex[2] = {1'b0, 5'd31, 1'b0, 1'b0};
    ex[3] = {TIE,  5'd0,  1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(cs[i], 1'b1);
      dif.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (dif.in_ready !== 1'b1) begin
        failures++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, dif.in_ready);
      end
      @(posedge clk); #1;
      dif.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (dif.out_valid !== 1'b0) begin
        failures++; $display("FAIL dir%0d_early_valid: got %b expected 0", i, dif.out_valid);
      end
      @(negedge clk);
      checks++;
      if (dif.out_valid !== 1'b1) begin
        failures++; $display("FAIL dir%0d_latency: got out_valid %b expected 1", i, dif.out_valid);
      end
      checks++;
      if ({dif.exchange_operands, dif.shift_amount, dif.effective_subtract, dif.out_sign_b} !== ex[i]) begin
        failures++;
        $display("FAIL dir%0d_fields: got %h expected %h", i,
                 {dif.exchange_operands, dif.shift_amount, dif.effective_subtract, dif.out_sign_b}, ex[i]);
      end
      checks++;
      if (observed() !== model(cs[i])) begin
        failures++; $display("FAIL dir%0d_model: got %h expected %h", i, observed(), model(cs[i]));
      end
      @(negedge clk);
      checks++;
      if (dif.out_valid !== 1'b0) begin
        failures++; $display("FAIL dir%0d_dup: got out_valid %b expected 0", i, dif.out_valid);
      end
    end
  endtask

  // Four back-to-back inputs with a three-cycle stall after the first result
  task automatic test_back_to_back();
    stim_t st[4];
    int idx = 0, got = 0, first_ov = -1;
    bit stall = 0, saw_low = 0;
    res_t held = '0;
    sb_q.delete();
    for (int i = 0; i < 4; i++) st[i] = rand_stim();
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      @(posedge clk); #1;
      if (dif.out_valid && first_ov < 0) first_ov = cyc;
      dif.out_ready = !(first_ov >= 0 && cyc < first_ov + 3);
      drive(st[idx < 4 ? idx : 3], idx < 4);
      @(negedge clk);
      if (stall) begin
        checks++;
        if ({dif.out_valid, observed()} !== {1'b1, held}) begin
          failures++; $display("FAIL b2b_hold: got %h expected %h", {dif.out_valid, observed()}, {1'b1, held});
        end
      end
      if (dif.out_valid && dif.out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++; $display("FAIL b2b_spurious: got %h expected none", observed());
        end else begin
          if (observed() !== sb_q[0]) begin
            failures++; $display("FAIL b2b_data%0d: got %h expected %h", got, observed(), sb_q[0]);
          end
          void'(sb_q.pop_front());
        end
        got++;
      end
      stall = dif.out_valid && !dif.out_ready;
      held  = observed();
      if (!dif.in_ready) saw_low = 1;
      if (dif.in_valid && dif.in_ready) begin
        sb_q.push_back(model(st[idx]));
        idx++;
      end
    end
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    dif.out_ready = 1'b1;
    checks++;
    if (got != 4 || sb_q.size() != 0) begin
      failures++; $display("FAIL b2b_count: got %0d left %0d expected 4 left 0", got, sb_q.size());
    end
    checks++;
    if (!saw_low) begin
      failures++; $display("FAIL b2b_in_ready: got never-low expected low when full");
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (dif.out_valid !== 1'b0) begin
        failures++; $display("FAIL b2b_extra: got out_valid %b expected 0", dif.out_valid);
      end
    end
  endtask

  task automatic test_random();
    stim_t cur;
    bit stall = 0;
    res_t held = '0;
    sb_q.delete();
    cur = rand_stim();
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(posedge clk); #1;
      dif.out_ready = (cyc >= 400) || ($urandom_range(0, 9) < 7);
      drive(cur, (cyc < 400) && ($urandom_range(0, 9) < 7));
      @(negedge clk);
      if (stall) begin
        checks++;
        if ({dif.out_valid, observed()} !== {1'b1, held}) begin
          failures++; $display("FAIL rnd_hold: got %h expected %h", {dif.out_valid, observed()}, {1'b1, held});
        end
      end
      if (dif.out_valid && dif.out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++; $display("FAIL rnd_spurious: got %h expected none", observed());
        end else begin
          if (observed() !== sb_q[0]) begin
            failures++; $display("FAIL rnd_data: got %h expected %h", observed(), sb_q[0]);
          end
          void'(sb_q.pop_front());
        end
      end
      stall = dif.out_valid && !dif.out_ready;
      held  = observed();
      if (dif.in_valid && dif.in_ready) begin
        sb_q.push_back(model(cur));
        cur = rand_stim();
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL rnd_drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    stim_t s;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    repeat (3) begin
      drive(rand_stim(), 1'b1);
      @(posedge clk); #1;
    end
    checks++;
    if (dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_fill: got valid %b ready %b expected 1 0", dif.out_valid, dif.in_ready);
    end
    reset = 1'b1;
    dif.in_valid = 1'b0;
    #1;
    checks++;
    if ({dif.out_valid, observed()} !== '0) begin
      failures++; $display("FAIL rst_async: got %h expected 0", {dif.out_valid, observed()});
    end
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    s = rand_stim();
    @(posedge clk); #1;
    drive(s, 1'b1);
    dif.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (dif.in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_in_ready: got %b expected 1", dif.in_ready);
    end
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dif.out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_stale: got out_valid %b expected 0", dif.out_valid);
    end
    @(negedge clk);
    checks++;
    if ({dif.out_valid, observed()} !== {1'b1, model(s)}) begin
      failures++; $display("FAIL rst_first: got %h expected %h", {dif.out_valid, observed()}, {1'b1, model(s)});
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (dif.out_valid !== 1'b0) begin
        failures++; $display("FAIL rst_extra: got out_valid %b expected 0", dif.out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exchange_decider.md
Name: exchange_decider

Overview:
Pipelined front stage of the FP add/sub datapath.
- Accepts two unpacked single-precision operands plus an add/subtract opcode.
- Decides whether the operands must be swapped so that operand A has the larger magnitude, and drives exchange_operands for the combinational swap stage.
- Computes the saturated alignment shift amount and the effective operation, with a valid/ready handshake on both sides.

Parameters:
SHIFT_SAT, 31, saturation limit of shift_amount; legal range 1..31.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  input operand set is valid
in_ready  output  1  block can accept an input this cycle
op_subtract  input  1  1 = A-B, 0 = A+B
sign_a  input  1  operand A sign
exponent_a  input  8  operand A biased exponent
fraction_a  input  24  operand A fraction, hidden bit included
sign_b  input  1  operand B sign
exponent_b  input  8  operand B biased exponent
fraction_b  input  24  operand B fraction, hidden bit included
out_valid  output  1  output set is valid
out_ready  input  1  downstream accepts the output this cycle
exchange_operands  output  1  1 = swap A and B
shift_amount  output  5  min(|exponent_a-exponent_b|, SHIFT_SAT)
effective_subtract  output  1  sign_a XOR (sign_b XOR op_subtract)
out_sign_a, out_exponent_a, out_fraction_a, out_sign_b, out_exponent_b, out_fraction_b  output  1/8/24 each  unswapped operands, sign_b already XORed with op_subtract

Behaviour:
- Reset is asynchronous active-high. While asserted and after release:
  - out_valid = 0, all data outputs = 0, both pipeline stages empty.
  - in_ready = 1 from the first clock after release.
- Pipeline: two register stages.
  - S1 registers the inputs and computes:
    - exp_gt_b = exponent_b > exponent_a
    - exp_eq = exponent_b == exponent_a
    - frac_gt_b = fraction_b > fraction_a
    - exp_diff = 9-bit signed exponent_a - exponent_b
  - S2 registers the final results:
    - exchange_operands = exp_gt_b | (exp_eq & frac_gt_b)
    - shift_amount = |exp_diff|, clamped to SHIFT_SAT
    - effective_subtract
    - passthrough operands
- Latency: exactly 2 clocks from an accepted input (in_valid & in_ready) to out_valid, when there is no backpressure. Throughput is 1 per clock.
- Handshake:
  - A transfer occurs on either side only when valid and ready are both 1 at the rising edge.
  - Stage advance:
    - s2_advance = !s2_valid | out_ready
    - s1_advance = !s1_valid | s2_advance
    - in_ready = s1_advance. This is a combinational path from out_ready and is permitted.
  - While out_valid = 1 and out_ready = 0, all outputs hold stable.
  - out_valid never drops without a transfer.
  - in_valid may drop at any time without a transfer. Inputs are sampled only when in_ready = 1.
- Equal magnitude (exponent and fraction both equal): exchange_operands = 0 and shift_amount = 0.
- The sign of the operands never affects exchange_operands, except as described under Optional Feature.
- Zero and denormal operands are treated by raw field value; no special casing.
- Subtraction: op_subtract is folded into sign_b at S1. out_sign_b is the effective sign, not the input sign.
- Simultaneous input accept and output transfer in the same cycle: both occur, and the pipeline stays full.
- Reset mid-operation discards all in-flight entries. Nothing is emitted for them.

Optional Feature:
Macro SIGN_TIEBREAK_EN.
- Defined:
  - On equal magnitude with out_sign_b = 0 and out_sign_a = 1 (effective signs differ), exchange_operands = 1.
  - The positive operand therefore becomes sorted A, so an exact-cancellation result takes the sign of sorted A = +0 in round-to-nearest.
  - Adds one comparator term at S2 and no latency.
- Undefined: equal magnitude always gives exchange_operands = 0. The downstream stage is responsible for the zero-sign fixup.

Test Plan:
1. A = 1.0 (exp 127, frac 0x800000), B = 2.0 (exp 128, frac 0x800000), add, out_ready = 1 -> 2 clocks later: out_valid = 1, exchange_operands = 1, shift_amount = 1, effective_subtract = 0.
2. A = exp 100 frac 0x800000, B = exp 100 frac 0xC00000, subtract, both signs 0 -> exchange_operands = 1, shift_amount = 0, out_sign_b = 1, effective_subtract = 1.
3. A = exp 254, B = exp 1, SHIFT_SAT = 31 -> exchange_operands = 0, shift_amount = 31.
4. Stream 4 back-to-back inputs; hold out_ready = 0 for 3 clocks after the first out_valid -> in_ready drops once both stages are full, outputs stay frozen, and all 4 results emerge in order once out_ready = 1, with none lost or duplicated.
5. Equal operands (exp 130, frac 0x900000) with sign_a = 1, sign_b = 0, add -> exchange_operands = 0 without the macro; exchange_operands = 1 with SIGN_TIEBREAK_EN.
6. Assert reset with both stages full -> out_valid = 0 immediately. After release, the first new input appears 2 clocks after acceptance and no stale data is emitted.
